// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: loads a program into instruction memory from a word
// stream, releases the core from reset, counts run cycles and stops the core
// on a jump-to-self halt or when the cycle limit is reached.
//
// Stream format: one header word (length in bits [15:0]), then `length`
// payload words. Each payload word goes to the next instruction memory word
// address, starting at 0.
//
// Optional feature, enabled by defining BOOT_LOADER_CHECKSUM_EN: after the
// payload, one extra checksum word (sum of payload words mod 2**32) is
// accepted. A mismatch flags err and ends in DONE without releasing the core.
//
// Debug: dbg_state exposes the FSM state
//   0 IDLE, 1 HDR, 2 LOAD, 3 CHK, 4 RUN, 5 DONE
module boot_loader_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [31:0]           in_data,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  input  logic [31:0]           pc,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  err,
  output logic [31:0]           cycle_count,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_LOAD = 3'd2,
    S_CHK  = 3'd3,
    S_RUN  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int CAPACITY = 1 << ADDR_WIDTH;

  state_t                state;
  logic [ADDR_WIDTH-1:0] word_cnt;
  logic [ADDR_WIDTH-1:0] last_idx;
  logic [31:0]           prev_pc;
  logic                  pc_stable;
  logic                  xfer;
  logic                  hdr_bad;
  logic                  run_halt;
  logic [31:0]           cycle_next;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [31:0]           sum;
`endif

  // Handshake: a word transfers on a rising edge where in_valid && in_ready.
  // in_ready depends only on the state, never on in_valid, and the source
  // holds in_data stable while in_valid is high and no transfer has occurred.
  always_comb begin
    in_ready = (state == S_HDR) || (state == S_LOAD) || (state == S_CHK);
  end

  assign xfer       = in_valid && in_ready;
  // Length 0 or larger than the memory cannot be loaded.
  assign hdr_bad    = (in_data[15:0] == 16'd0) ||
                      ({16'd0, in_data[15:0]} > 32'(CAPACITY));
  // Halt: pc unchanged across two consecutive edges; edges during the first
  // RUN cycle are skipped because the core is still held in reset then.
  assign run_halt   = (cycle_count != 32'd0) && (pc == prev_pc) && pc_stable;
  assign cycle_next = cycle_count + 32'd1;
  assign dbg_state  = state;

  // Main sequencer: state, registered outputs and load/run bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
      cpu_reset   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      err         <= 1'b0;
      cycle_count <= 32'd0;
      word_cnt    <= '0;
      last_idx    <= '0;
      prev_pc     <= 32'd0;
      pc_stable   <= 1'b0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum         <= 32'd0;
`endif
    end else begin
      imem_we   <= 1'b0;
      prev_pc   <= pc;
      // The core is released one cycle after RUN entry and re-held one cycle
      // after RUN exit.
      cpu_reset <= (state != S_RUN);

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_HDR;
            busy        <= 1'b1;
            err         <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= 32'd0;
          end
        end

        S_HDR: begin
          if (xfer) begin
            if (hdr_bad) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              last_idx <= ADDR_WIDTH'(in_data[15:0] - 16'd1);
              word_cnt <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
              sum      <= 32'd0;
`endif
              state    <= S_LOAD;
            end
          end
        end

        S_LOAD: begin
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= word_cnt;
            imem_wdata <= in_data;
            word_cnt   <= word_cnt + ADDR_WIDTH'(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
            sum        <= sum + in_data;
`endif
            if (word_cnt == last_idx) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
              state     <= S_CHK;
`else
              state     <= S_RUN;
              pc_stable <= 1'b0;
`endif
            end
          end
        end

`ifdef BOOT_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            if (in_data == sum) begin
              state     <= S_RUN;
              pc_stable <= 1'b0;
            end else begin
              err   <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
`endif

        S_RUN: begin
          cycle_count <= cycle_next;
          pc_stable   <= (cycle_count != 32'd0) && (pc == prev_pc);
          if (run_halt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (cycle_next == 32'(MAX_CYCLES)) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_DONE;
          end
        end

        S_DONE: begin
          if (start) begin
            state       <= S_HDR;
            done        <= 1'b0;
            busy        <= 1'b1;
            err         <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= 32'd0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl: directed bench for boot_loader_ctrl with a small
// program-level model of the core (pc trace) and a write scoreboard.
module tb_boot_loader_ctrl;

  localparam int AW   = 8;
  localparam int MAXC = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic [31:0]   pc;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_reset;
  logic          busy;
  logic          done;
  logic          timeout;
  logic          err;
  logic [31:0]   cycle_count;
  logic [2:0]    dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  bit released = 1'b0;

  logic [AW+31:0] exp_q[$];
  logic [31:0]    img [0:255];
  logic [31:0]    cur_instr;

  boot_loader_ctrl #(.ADDR_WIDTH(AW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset(cpu_reset),
    .pc(pc), .busy(busy), .done(done), .timeout(timeout), .err(err),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion within 500000 time units");
    $fatal(1);
  end

  // ---------------- core stand-in ----------------
  // Executes the image the bench loaded: j (opcode 2) jumps, everything else
  // falls through to pc+4. Held at 0 while cpu_reset is high.
  assign cur_instr = img[pc[9:2]];
  always @(posedge clk) begin
    if (cpu_reset === 1'b1) pc <= 32'd0;
    else if (cur_instr[31:26] == 6'h02) pc <= {pc[31:28], cur_instr[25:0], 2'b00};
    else pc <= pc + 32'd4;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [AW+31:0] e;
    if (imem_we === 1'b1) begin
      pulses++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL imem_write: got addr=%0h data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          miscompares++;
          $display("FAIL imem_write: got addr=%0h data=%h, expected addr=%0h data=%h",
                   imem_addr, imem_wdata, e[AW+31:32], e[31:0]);
        end
      end
    end
    if (cpu_reset === 1'b0) released = 1'b1;
    if (reset) begin
      vectors++;
      if (busy && done) begin
        miscompares++;
        $display("FAIL busy_done_excl: got busy=%b done=%b, expected not both", busy, done);
      end
      vectors++;
      if (in_ready && !busy) begin
        miscompares++;
        $display("FAIL ready_in_busy: got in_ready=%b busy=%b, expected busy when ready", in_ready, busy);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Expected run from the program image: p[0]=p[1]=0 (core still held / first
  // fetch), then each step follows the instruction at p. Halt is the first j
  // with p[j]==p[j-1]==p[j-2]; cycle_count is j+1, capped at MAXC (timeout).
  function automatic void run_model(output int cnt, output bit to);
    logic [31:0] p[$];
    logic [31:0] cur;
    logic [31:0] w;
    p.push_back(32'd0);
    p.push_back(32'd0);
    cnt = MAXC;
    to  = 1'b1;
    for (int j = 2; j + 1 <= MAXC; j++) begin
      cur = p[j-1];
      w   = img[cur[9:2]];
      p.push_back((w[31:26] == 6'h02) ? {cur[31:28], w[25:0], 2'b00} : cur + 32'd4);
      if (p[j] == p[j-1] && p[j-1] == p[j-2]) begin
        cnt = j + 1;
        to  = 1'b0;
        return;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    chk({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_cycle_count"}, cycle_count, 32'd0);
    chk({tag, "_state_idle"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic do_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({tag, "_start_busy"}, 32'(busy), 32'd1);
    chk({tag, "_start_done"}, 32'(done), 32'd0);
    chk({tag, "_start_err_clr"}, 32'(err), 32'd0);
    chk({tag, "_start_to_clr"}, 32'(timeout), 32'd0);
    chk({tag, "_start_cnt_clr"}, cycle_count, 32'd0);
  endtask

  task automatic send_word(input logic [31:0] d, input bit gap);
    int t;
    if (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (in_ready) @(posedge clk);
    else begin
      vectors++;
      miscompares++;
      $display("FAIL in_ready_wait: got in_ready=0, expected 1 within 50 cycles");
    end
  endtask

  task automatic stream_idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'd0;
  endtask

  task automatic load(input string tag, input logic [31:0] prog[$], input bit gap,
                      input bit corrupt_sum);
    logic [31:0] s;
    s = 32'd0;
    do_start(tag);
    send_word(32'(prog.size()), 1'b0);
    for (int i = 0; i < prog.size(); i++) begin
      exp_q.push_back({AW'(i), prog[i]});
      img[i] = prog[i];
      s = s + prog[i];
      send_word(prog[i], gap);
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    send_word(corrupt_sum ? s + 32'd1 : s, gap);
`endif
    stream_idle();
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_wait_done: got done=0, expected 1 within 200 cycles", tag);
    end
  endtask

  task automatic run_prog(input string tag, input logic [31:0] prog[$], input bit gap,
                          input int lit_cnt);
    int ecnt;
    bit eto;
    pulses   = 0;
    released = 1'b0;
    load(tag, prog, gap, 1'b0);
    run_model(ecnt, eto);
    wait_done(tag);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout), 32'(eto));
    chk({tag, "_cycles_model"}, cycle_count, 32'(ecnt));
    chk({tag, "_cycles_literal"}, cycle_count, 32'(lit_cnt));
    chk({tag, "_pulses"}, 32'(pulses), 32'(prog.size()));
    chk({tag, "_exp_q_empty"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_released"}, 32'(released), 32'd1);
    @(negedge clk);
    chk({tag, "_cpu_reset_done"}, 32'(cpu_reset), 32'd1);
  endtask

  task automatic bad_header(input string tag, input logic [31:0] hdr);
    pulses   = 0;
    released = 1'b0;
    do_start(tag);
    send_word(hdr, 1'b0);
    stream_idle();
    wait_done(tag);
    chk({tag, "_err"}, 32'(err), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_timeout"}, 32'(timeout), 32'd0);
    chk({tag, "_cycles"}, cycle_count, 32'd0);
    chk({tag, "_pulses"}, 32'(pulses), 32'd0);
    chk({tag, "_released"}, 32'(released), 32'd0);
    @(negedge clk);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] basic[$];
    logic [31:0] spin[$];
    logic [31:0] gapped[$];
    logic [31:0] full[$];
    for (int i = 0; i < 256; i++) img[i] = 32'd0;
    basic  = '{32'h20080005, 32'h20090007, 32'h08000002};
    spin   = '{32'h20080001, 32'h08000000};
    gapped = '{32'h20080001, 32'h20080002, 32'h20080003, 32'h08000003};
    for (int i = 0; i < 256; i++) full.push_back({6'h08, 26'(i * 7 + 1)});

    // Reset held from time 0.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b1;

    // Three-word program halting on the jump-to-self at byte 8.
    run_prog("basic", basic, 1'b0, 6);

    // Header length 0 and 257 (one past capacity), started from DONE.
    bad_header("hdr0", 32'd0);
    bad_header("hdr257", 32'd257);

    // Never self-loops: ends on the cycle limit.
    run_prog("timeout", spin, 1'b0, MAXC);

    // in_valid toggles every cycle during a 4-word load.
    run_prog("gapped", gapped, 1'b1, 7);

    // Length equal to capacity is legal.
    run_prog("full", full, 1'b0, MAXC);

    // Reset held 2 cycles in the middle of a load.
    pulses = 0;
    do_start("midrst");
    send_word(32'd4, 1'b0);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({AW'(i), 32'hA5A50000 + 32'(i)});
      img[i] = 32'hA5A50000 + 32'(i);
      send_word(32'hA5A50000 + 32'(i), 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("midrst");
    chk("midrst_pulses", 32'(pulses), 32'd2);
    chk("midrst_exp_q_empty", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;

    // Normal operation resumes from IDLE.
    run_prog("recover", basic, 1'b0, 6);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Correct checksum 0x3 runs; image word 2 is still the jump-to-self.
    run_prog("chk_ok", '{32'h1, 32'h2}, 1'b0, 6);
    // Wrong checksum 0x4: error, core never released.
    pulses   = 0;
    released = 1'b0;
    load("chk_bad", '{32'h1, 32'h2}, 1'b0, 1'b1);
    wait_done("chk_bad");
    chk("chk_bad_err", 32'(err), 32'd1);
    chk("chk_bad_done", 32'(done), 32'd1);
    chk("chk_bad_cycles", cycle_count, 32'd0);
    chk("chk_bad_pulses", 32'(pulses), 32'd2);
    chk("chk_bad_released", 32'(released), 32'd0);
    @(negedge clk);
    chk("chk_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
